cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 145 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Single-port word memory serving one CPU transaction at a time on a fetch channel and a data
// channel. Request and response latencies can be configured, and data requests win over fetches.
module cpu_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned REQ_LAT   = 1,
  parameter int unsigned RESP_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StAccept, StRespDly, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        sel_data_q;
  logic [31:0] inst_q;
  logic [31:0] rdata_q;
  logic        inst_valid_q;
  logic        rdata_valid_q;

  logic [31:0] mem_q [MEM_WORDS];

  logic [AW-1:0] data_idx;
  logic [AW-1:0] inst_idx;
  logic          sel_valid;
  logic          accept;
  logic          store_en;
  logic          unused_addr;

  // High address bits alias onto the array; the byte offset is irrelevant for word access.
  assign data_idx    = Address[AW+1:2];
  assign inst_idx    = PC[AW+1:2];
  assign unused_addr = ^{Address[31:AW+2], Address[1:0], PC[31:AW+2], PC[1:0]};

  assign sel_valid = sel_data_q ? (MemRead | MemWrite) : Inst_Req_Valid;
  assign accept    = (state_q == StAccept) && (cnt_q == 4'd0) && sel_valid;
  assign store_en  = accept && sel_data_q && MemWrite;

  assign Inst_Req_Ready  = accept && !sel_data_q;
  assign Mem_Req_Ready   = accept && sel_data_q;
  assign Instruction     = inst_q;
  assign Read_data       = rdata_q;
  assign Inst_Valid      = inst_valid_q;
  assign Read_data_Valid = rdata_valid_q;

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem_q[data_idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      sel_data_q    <= 1'b0;
      inst_q        <= 32'd0;
      rdata_q       <= 32'd0;
      inst_valid_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MemRead || MemWrite) begin
            sel_data_q <= 1'b1;
            cnt_q      <= 4'(REQ_LAT);
            state_q    <= StAccept;
          end else if (Inst_Req_Valid) begin
            sel_data_q <= 1'b0;
            cnt_q      <= 4'(REQ_LAT);
            state_q    <= StAccept;
          end
        end
        StAccept: begin
          if (!sel_valid) begin
            cnt_q   <= 4'd0;
            state_q <= StIdle;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (sel_data_q && MemWrite) begin
            state_q <= StIdle;
          end else begin
            // Nonblocking read sees the word as it was before this edge.
            if (sel_data_q) begin
              rdata_q <= mem_q[data_idx];
            end else begin
              inst_q <= mem_q[inst_idx];
            end
            if (RESP_LAT == 0) begin
              cnt_q         <= 4'd0;
              state_q       <= StResp;
              rdata_valid_q <= sel_data_q;
              inst_valid_q  <= !sel_data_q;
            end else begin
              cnt_q   <= 4'(RESP_LAT);
              state_q <= StRespDly;
            end
          end
        end
        StRespDly: begin
          if (cnt_q <= 4'd1) begin
            cnt_q         <= 4'd0;
            state_q       <= StResp;
            rdata_valid_q <= sel_data_q;
            inst_valid_q  <= !sel_data_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (sel_data_q ? Read_data_Ready : Inst_Ready) begin
            rdata_valid_q <= 1'b0;
            inst_valid_q  <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder at default parameters (4096 words, REQ_LAT=1, RESP_LAT=1).
module tb_cpu_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  int n_checks;
  int n_fail;

  cpu_mem_responder #(
    .MEM_WORDS(4096),
    .REQ_LAT  (1),
    .RESP_LAT (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Inst_Req_Valid (Inst_Req_Valid),
    .Inst_Req_Ready (Inst_Req_Ready),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .Address        (Address),
    .MemWrite       (MemWrite),
    .Write_data     (Write_data),
    .Write_strb     (Write_strb),
    .MemRead        (MemRead),
    .Mem_Req_Ready  (Mem_Req_Ready),
    .Read_data      (Read_data),
    .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle indices below count negedges from the cycle in which the request was first driven.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int rc);
    int k;
    rc = 99;
    k  = 0;
    @(posedge clk); #1;
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
    while (rc == 99 && k < 30) begin
      @(negedge clk);
      if (Mem_Req_Ready) rc = k;
      k++;
    end
    @(posedge clk); #1;
    MemWrite = 1'b0; Write_strb = 4'h0;
  endtask

  task automatic do_load(input logic [31:0] addr, output int rc, output int vc,
                         output logic [31:0] d);
    int k;
    rc = 99; vc = 99; d = 32'h0; k = 0;
    @(posedge clk); #1;
    Address = addr; MemRead = 1'b1;
    while (rc == 99 && k < 30) begin
      @(negedge clk);
      if (Mem_Req_Ready) rc = k;
      k++;
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    while (vc == 99 && k < 30) begin
      @(negedge clk);
      if (Read_data_Valid) begin
        vc = k; d = Read_data; Read_data_Ready = 1'b1;
      end
      k++;
    end
    @(posedge clk); #1;
    Read_data_Ready = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, output int rc, output int vc,
                          output logic [31:0] d);
    int k;
    rc = 99; vc = 99; d = 32'h0; k = 0;
    @(posedge clk); #1;
    PC = pc; Inst_Req_Valid = 1'b1;
    while (rc == 99 && k < 30) begin
      @(negedge clk);
      if (Inst_Req_Ready) rc = k;
      k++;
    end
    @(posedge clk); #1;
    Inst_Req_Valid = 1'b0;
    while (vc == 99 && k < 30) begin
      @(negedge clk);
      if (Inst_Valid) begin
        vc = k; d = Instruction; Inst_Ready = 1'b1;
      end
      k++;
    end
    @(posedge clk); #1;
    Inst_Ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s handshakes: got %b expected 0000", tag,
               {Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid});
    end
    n_checks++;
    if (Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL %s Instruction: got %h expected 00000000", tag, Instruction);
    end
    n_checks++;
    if (Read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s Read_data: got %h expected 00000000", tag, Read_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_fetch();
    int rc, vc;
    logic [31:0] d;
    do_store(32'h100, 32'hDEADBEEF, 4'hF, rc);
    n_checks++;
    if (rc !== 2) begin n_fail++; $display("FAIL store ready cycle: got %0d expected 2", rc); end
    do_fetch(32'h100, rc, vc, d);
    n_checks++;
    if (rc !== 2) begin n_fail++; $display("FAIL fetch ready cycle: got %0d expected 2", rc); end
    n_checks++;
    if (vc !== 4) begin n_fail++; $display("FAIL fetch valid cycle: got %0d expected 4", vc); end
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch data: got %h expected deadbeef", d);
    end
  endtask

  task automatic test_byte_strobe();
    int rc, vc;
    logic [31:0] d;
    do_store(32'h200, 32'h11223344, 4'hF, rc);
    do_store(32'h201, 32'h0000AA00, 4'b0010, rc);
    do_load(32'h200, rc, vc, d);
    n_checks++;
    if (d !== 32'h1122AA44) begin
      n_fail++; $display("FAIL strobe lane1: got %h expected 1122aa44", d);
    end
    n_checks++;
    if (rc !== 2 || vc !== 4) begin
      n_fail++; $display("FAIL load timing: got %0d/%0d expected 2/4", rc, vc);
    end
    do_store(32'h300, 32'hAABBCCDD, 4'hF, rc);
    do_store(32'h300, 32'h11000022, 4'b1001, rc);
    do_load(32'h302, rc, vc, d);
    n_checks++;
    if (d !== 32'h11BBCC22) begin
      n_fail++; $display("FAIL strobe lanes0_3: got %h expected 11bbcc22", d);
    end
  endtask

  task automatic test_priority();
    int mr_k, ir_k, rv_k, iv_k;
    logic [31:0] rd, id;
    mr_k = 99; ir_k = 99; rv_k = 99; iv_k = 99; rd = 32'h0; id = 32'h0;
    @(posedge clk); #1;
    Address = 32'h200; PC = 32'h100; MemRead = 1'b1; Inst_Req_Valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Mem_Req_Ready && mr_k == 99) mr_k = k;
      if (Inst_Req_Ready && ir_k == 99) ir_k = k;
      if (Read_data_Valid && rv_k == 99) begin rv_k = k; rd = Read_data; Read_data_Ready = 1'b1; end
      if (Inst_Valid && iv_k == 99) begin iv_k = k; id = Instruction; Inst_Ready = 1'b1; end
      @(posedge clk); #1;
      if (mr_k != 99) MemRead = 1'b0;
      if (ir_k != 99) Inst_Req_Valid = 1'b0;
      Read_data_Ready = 1'b0;
      Inst_Ready = 1'b0;
      if (iv_k != 99) break;
    end
    MemRead = 1'b0; Inst_Req_Valid = 1'b0;
    n_checks++;
    if (mr_k !== 2) begin n_fail++; $display("FAIL prio data ready: got %0d expected 2", mr_k); end
    n_checks++;
    if (rv_k !== 4) begin n_fail++; $display("FAIL prio data valid: got %0d expected 4", rv_k); end
    n_checks++;
    if (ir_k !== 7) begin n_fail++; $display("FAIL prio fetch ready: got %0d expected 7", ir_k); end
    n_checks++;
    if (iv_k !== 9) begin n_fail++; $display("FAIL prio fetch valid: got %0d expected 9", iv_k); end
    n_checks++;
    if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL prio rdata: got %h expected 1122aa44", rd); end
    n_checks++;
    if (id !== 32'hDEADBEEF) begin n_fail++; $display("FAIL prio inst: got %h expected deadbeef", id); end
  endtask

  task automatic test_backpressure();
    int k;
    int rc;
    int vc;
    rc = 99; vc = 99; k = 0;
    @(posedge clk); #1;
    Address = 32'h100; MemRead = 1'b1;
    while (rc == 99 && k < 30) begin
      @(negedge clk);
      if (Mem_Req_Ready) rc = k;
      k++;
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    while (vc == 99 && k < 30) begin
      @(negedge clk);
      if (Read_data_Valid) vc = k;
      k++;
    end
    n_checks++;
    if (vc !== 4) begin n_fail++; $display("FAIL bp valid cycle: got %0d expected 4", vc); end
    // Competing requests while the response is stalled must not be accepted.
    MemRead = 1'b1; Inst_Req_Valid = 1'b1; PC = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({Read_data_Valid, Mem_Req_Ready, Inst_Req_Ready} !== 3'b100 || Read_data !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL bp hold %0d: got v/mr/ir=%b data=%h expected 100 deadbeef", i,
                 {Read_data_Valid, Mem_Req_Ready, Inst_Req_Ready}, Read_data);
      end
    end
    MemRead = 1'b0; Inst_Req_Valid = 1'b0; Read_data_Ready = 1'b1;
    @(posedge clk); #1;
    Read_data_Ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (Read_data_Valid !== 1'b0) begin
      n_fail++; $display("FAIL bp release: got %b expected 0", Read_data_Valid);
    end
  endtask

  task automatic test_abort();
    int rc, vc;
    logic seen;
    logic [31:0] d;
    seen = 1'b0;
    @(posedge clk); #1;
    Address = 32'h100; Write_data = 32'h0; Write_strb = 4'hF; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; Write_strb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (Mem_Req_Ready) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort ready: got 1 expected 0"); end
    do_load(32'h100, rc, vc, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort mem: got %h expected deadbeef", d); end
  endtask

  task automatic test_wrap();
    int rc, vc;
    logic [31:0] d;
    do_store(32'h4000, 32'h5, 4'hF, rc);
    do_load(32'h0, rc, vc, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL wrap load 0x0: got %h expected 00000005", d); end
    do_load(32'h8000, rc, vc, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL wrap load 0x8000: got %h expected 00000005", d); end
  endtask

  task automatic test_reset_mid();
    int rc, vc, k;
    logic seen;
    logic [31:0] d;
    seen = 1'b0; rc = 99; k = 0;
    do_store(32'h40, 32'hCAFEF00D, 4'hF, rc);
    rc = 99;
    @(posedge clk); #1;
    Address = 32'h40; MemRead = 1'b1;
    while (rc == 99 && k < 30) begin
      @(negedge clk);
      if (Mem_Req_Ready) rc = k;
      k++;
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    #1 rst = 1'b1;
    #1 check_outputs_zero("mid reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Read_data_Valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset drop resp: got 1 expected 0"); end
    do_load(32'h40, rc, vc, d);
    n_checks++;
    if (d !== 32'hCAFEF00D || rc !== 2 || vc !== 4) begin
      n_fail++;
      $display("FAIL reset mem: got %h %0d/%0d expected cafef00d 2/4", d, rc, vc);
    end
    do_fetch(32'h100, rc, vc, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset mem2: got %h expected deadbeef", d); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; PC = 32'h0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
    Address = 32'h0; MemWrite = 1'b0; Write_data = 32'h0; Write_strb = 4'h0;
    MemRead = 1'b0; Read_data_Ready = 1'b0;
    test_reset();
    test_store_fetch();
    test_byte_strobe();
    test_priority();
    test_backpressure();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
